// File: rtl/rob_completion_tracker_if.sv
// ---------------------------------------------------------------------------
// rob_completion_tracker_if
// Bundles every non-clock/reset signal of the ROB completion tracker.
//   master modport : upstream side (rename/alloc, execution ports, commit consumer)
//   slave  modport : the tracker itself
// Signals:
//   flush_i               pipeline flush
//   alloc_valid_i         allocate one pack at tail
//   alloc_slot_vld_i[2]   occupancy of the allocated pack
//   alloc_pack_o          pack id the next allocation receives
//   full_o / empty_o      occupancy flags
//   alu0/alu1/mem_*       completion strobes with rob id {pack,slot}
//   excp_valid_i          exception report, rob id in excp_rob_i[4:0], cause in excp_code_i
//   commit_valid_o/pack/mask, commit_ready_i   in-order retirement handshake
//   trap_valid_o/rob/code sticky trap report
// ---------------------------------------------------------------------------
interface rob_completion_tracker_if #(
    parameter int PACKS  = 16,
    parameter int CODE_W = 5
);
    localparam int IDX_W = $clog2(PACKS);
    localparam int ROB_W = IDX_W + 1;

    logic              flush_i;
    logic              alloc_valid_i;
    logic [1:0]        alloc_slot_vld_i;
    logic [IDX_W-1:0]  alloc_pack_o;
    logic              full_o;
    logic              empty_o;
    logic              alu0_complete_i;
    logic [ROB_W-1:0]  alu0_rob_id_i;
    logic              alu1_complete_i;
    logic [ROB_W-1:0]  alu1_rob_id_i;
    logic              mem_complete_i;
    logic [ROB_W-1:0]  mem_rob_id_i;
    logic              excp_valid_i;
    logic [ROB_W:0]    excp_rob_i;
    logic [CODE_W-1:0] excp_code_i;
    logic              commit_valid_o;
    logic [IDX_W-1:0]  commit_pack_o;
    logic [1:0]        commit_mask_o;
    logic              commit_ready_i;
    logic              trap_valid_o;
    logic [ROB_W-1:0]  trap_rob_o;
    logic [CODE_W-1:0] trap_code_o;

    modport master (
        output flush_i, alloc_valid_i, alloc_slot_vld_i,
        output alu0_complete_i, alu0_rob_id_i, alu1_complete_i, alu1_rob_id_i,
        output mem_complete_i, mem_rob_id_i,
        output excp_valid_i, excp_rob_i, excp_code_i, commit_ready_i,
        input  alloc_pack_o, full_o, empty_o,
        input  commit_valid_o, commit_pack_o, commit_mask_o,
        input  trap_valid_o, trap_rob_o, trap_code_o
    );

    modport slave (
        input  flush_i, alloc_valid_i, alloc_slot_vld_i,
        input  alu0_complete_i, alu0_rob_id_i, alu1_complete_i, alu1_rob_id_i,
        input  mem_complete_i, mem_rob_id_i,
        input  excp_valid_i, excp_rob_i, excp_code_i, commit_ready_i,
        output alloc_pack_o, full_o, empty_o,
        output commit_valid_o, commit_pack_o, commit_mask_o,
        output trap_valid_o, trap_rob_o, trap_code_o
    );
endinterface

// File: rtl/rob_completion_tracker.sv
// ---------------------------------------------------------------------------
// rob_completion_tracker
// In-order completion/commit tracker for 2-slot packs (rob_id = {pack,slot}).
// Collects out-of-order completions from ALU0, ALU1 and memory, records
// exceptions per slot, retires the head pack in order and raises a sticky
// trap when the head's oldest live instruction faulted.
// Ports:
//   cpu_clock_i    clock, rising edge
//   cpu_reset_n_i  asynchronous active-low reset
//   bus            rob_completion_tracker_if.slave (alloc, completion,
//                  exception, commit and trap signals)
// ---------------------------------------------------------------------------
module rob_completion_tracker #(
    parameter int PACKS  = 16,
    parameter int CODE_W = 5
) (
    input  logic                     cpu_clock_i,
    input  logic                     cpu_reset_n_i,
    rob_completion_tracker_if.slave  bus
);
    localparam int IDX_W = $clog2(PACKS);
    localparam int PTR_W = IDX_W + 1;
    localparam int ROB_W = IDX_W + 1;

    logic [PTR_W-1:0]                   r_head;
    logic [PTR_W-1:0]                   r_tail;
    logic [PACKS-1:0][1:0]              r_occ;
    logic [PACKS-1:0][1:0]              r_done;
    logic [PACKS-1:0][1:0]              r_excp;
    logic [PACKS-1:0][1:0][CODE_W-1:0]  r_code;
    logic                               r_trap;
    logic [ROB_W-1:0]                   r_trap_rob;
    logic [CODE_W-1:0]                  r_trap_code;

    logic             w_full;
    logic             w_empty;
    logic [IDX_W-1:0] w_h_idx;
    logic [1:0]       w_h_occ;
    logic [1:0]       w_h_done;
    logic [1:0]       w_h_excp;
    logic             w_commit_valid;
    logic [1:0]       w_commit_mask;
    logic             w_partial;
    logic             w_trap_set;
    logic             w_trap_slot;
    logic             w_pop;
    logic             w_alloc;
    logic [ROB_W-1:0] w_ex_rob;
    logic             w_unused_excp_msb;

    assign w_full   = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) && (r_head[IDX_W] != r_tail[IDX_W]);
    assign w_empty  = (r_head == r_tail);
    assign w_h_idx  = r_head[IDX_W-1:0];
    assign w_h_occ  = r_occ[w_h_idx];
    assign w_h_done = r_done[w_h_idx];
    assign w_h_excp = r_excp[w_h_idx];
    assign w_ex_rob = bus.excp_rob_i[ROB_W-1:0];
    assign w_unused_excp_msb = bus.excp_rob_i[ROB_W];

    // Head-pack commit eligibility and trap detection.
    // When the oldest live slot has faulted nothing retires; the trap is
    // latched instead (this also covers slot1 after slot0 retired alone).
    always_comb begin
        w_commit_valid = 1'b0;
        w_commit_mask  = 2'b00;
        w_partial      = 1'b0;
        w_trap_set     = 1'b0;
        w_trap_slot    = 1'b0;
        if (!w_empty && !r_trap) begin
            if (w_h_occ[0] && w_h_excp[0]) begin
                w_trap_set  = 1'b1;
                w_trap_slot = 1'b0;
            end else if (w_h_occ[1] && w_h_excp[1]) begin
                if (!w_h_occ[0]) begin
                    w_trap_set  = 1'b1;
                    w_trap_slot = 1'b1;
                end else if (w_h_done[0]) begin
                    w_commit_valid = 1'b1;
                    w_commit_mask  = 2'b01;
                    w_partial      = 1'b1;
                end else begin
                    w_commit_valid = 1'b0;
                end
            end else if ((w_h_occ & ~w_h_done) == 2'b00) begin
                w_commit_valid = 1'b1;
                w_commit_mask  = w_h_occ;
            end else begin
                w_commit_valid = 1'b0;
            end
        end else begin
            w_commit_valid = 1'b0;
        end
    end

    assign w_pop   = w_commit_valid && bus.commit_ready_i;
    assign w_alloc = bus.alloc_valid_i && !w_full;

    // Tracker state: pointers, per-slot bits, code RAM and trap registers.
    // Completions are gated by occ alone: occ is zero for every pack that is
    // not in flight, so it doubles as the in-flight check. Alloc is written
    // last so it overrides anything aimed at the tail entry.
    always_ff @(posedge cpu_clock_i or negedge cpu_reset_n_i) begin
        if (!cpu_reset_n_i) begin
            r_head      <= {PTR_W{1'b0}};
            r_tail      <= {PTR_W{1'b0}};
            r_occ       <= '0;
            r_done      <= '0;
            r_excp      <= '0;
            r_code      <= '0;
            r_trap      <= 1'b0;
            r_trap_rob  <= {ROB_W{1'b0}};
            r_trap_code <= {CODE_W{1'b0}};
        end else if (bus.flush_i) begin
            r_head      <= {PTR_W{1'b0}};
            r_tail      <= {PTR_W{1'b0}};
            r_occ       <= '0;
            r_done      <= '0;
            r_excp      <= '0;
            r_code      <= '0;
            r_trap      <= 1'b0;
            r_trap_rob  <= {ROB_W{1'b0}};
            r_trap_code <= {CODE_W{1'b0}};
        end else begin
            if (bus.alu0_complete_i && r_occ[bus.alu0_rob_id_i[ROB_W-1:1]][bus.alu0_rob_id_i[0]]) begin
                r_done[bus.alu0_rob_id_i[ROB_W-1:1]][bus.alu0_rob_id_i[0]] <= 1'b1;
            end
            if (bus.alu1_complete_i && r_occ[bus.alu1_rob_id_i[ROB_W-1:1]][bus.alu1_rob_id_i[0]]) begin
                r_done[bus.alu1_rob_id_i[ROB_W-1:1]][bus.alu1_rob_id_i[0]] <= 1'b1;
            end
            if (bus.mem_complete_i && r_occ[bus.mem_rob_id_i[ROB_W-1:1]][bus.mem_rob_id_i[0]]) begin
                r_done[bus.mem_rob_id_i[ROB_W-1:1]][bus.mem_rob_id_i[0]] <= 1'b1;
            end
            if (bus.excp_valid_i && r_occ[w_ex_rob[ROB_W-1:1]][w_ex_rob[0]]) begin
                r_done[w_ex_rob[ROB_W-1:1]][w_ex_rob[0]] <= 1'b1;
                r_excp[w_ex_rob[ROB_W-1:1]][w_ex_rob[0]] <= 1'b1;
                r_code[w_ex_rob[ROB_W-1:1]][w_ex_rob[0]] <= bus.excp_code_i;
            end
            if (w_pop) begin
                if (w_partial) begin
                    // slot0 retires alone; slot1 stays as the faulting head
                    r_occ[w_h_idx][0] <= 1'b0;
                end else begin
                    r_occ[w_h_idx]  <= 2'b00;
                    r_done[w_h_idx] <= 2'b00;
                    r_excp[w_h_idx] <= 2'b00;
                    r_head          <= r_head + {{(PTR_W-1){1'b0}}, 1'b1};
                end
            end
            if (w_alloc) begin
                r_occ[r_tail[IDX_W-1:0]]  <= bus.alloc_slot_vld_i;
                r_done[r_tail[IDX_W-1:0]] <= ~bus.alloc_slot_vld_i;
                r_excp[r_tail[IDX_W-1:0]] <= 2'b00;
                r_tail                    <= r_tail + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (w_trap_set) begin
                r_trap      <= 1'b1;
                r_trap_rob  <= {w_h_idx, w_trap_slot};
                r_trap_code <= r_code[w_h_idx][w_trap_slot];
            end
        end
    end

    assign bus.alloc_pack_o   = r_tail[IDX_W-1:0];
    assign bus.full_o         = w_full;
    assign bus.empty_o        = w_empty;
    assign bus.commit_valid_o = w_commit_valid;
    assign bus.commit_pack_o  = w_h_idx;
    assign bus.commit_mask_o  = w_commit_mask;
    assign bus.trap_valid_o   = r_trap;
    assign bus.trap_rob_o     = r_trap_rob;
    assign bus.trap_code_o    = r_trap_code;
endmodule

// File: tb/tb_rob_completion_tracker.sv
// ---------------------------------------------------------------------------
// tb_rob_completion_tracker
// Directed self-checking bench for rob_completion_tracker.
// ---------------------------------------------------------------------------
module tb_rob_completion_tracker;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    rob_completion_tracker_if bus ();

    rob_completion_tracker dut (
        .cpu_clock_i   (clk),
        .cpu_reset_n_i (rst_n),
        .bus           (bus.slave)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush_i          = 1'b0;
        bus.alloc_valid_i    = 1'b0;
        bus.alloc_slot_vld_i = 2'b00;
        bus.alu0_complete_i  = 1'b0;
        bus.alu0_rob_id_i    = 5'd0;
        bus.alu1_complete_i  = 1'b0;
        bus.alu1_rob_id_i    = 5'd0;
        bus.mem_complete_i   = 1'b0;
        bus.mem_rob_id_i     = 5'd0;
        bus.excp_valid_i     = 1'b0;
        bus.excp_rob_i       = 6'd0;
        bus.excp_code_i      = 5'd0;
        bus.commit_ready_i   = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] vld);
        bus.alloc_valid_i    = 1'b1;
        bus.alloc_slot_vld_i = vld;
        tick();
        bus.alloc_valid_i    = 1'b0;
        bus.alloc_slot_vld_i = 2'b00;
    endtask

    task automatic flush();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_empty"},  32'(bus.empty_o),        32'd1);
        check_val({tag, "_full"},   32'(bus.full_o),         32'd0);
        check_val({tag, "_apack"},  32'(bus.alloc_pack_o),   32'd0);
        check_val({tag, "_cvalid"}, 32'(bus.commit_valid_o), 32'd0);
        check_val({tag, "_cmask"},  32'(bus.commit_mask_o),  32'd0);
        check_val({tag, "_tvalid"}, 32'(bus.trap_valid_o),   32'd0);
        check_val({tag, "_trob"},   32'(bus.trap_rob_o),     32'd0);
        check_val({tag, "_tcode"},  32'(bus.trap_code_o),    32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rst_n = 1'b0;
        #12;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Basic completion out of order then commit
        alloc(2'b11);
        check_val("a0_apack",  32'(bus.alloc_pack_o),   32'd1);
        check_val("a0_empty",  32'(bus.empty_o),        32'd0);
        check_val("a0_cvalid", 32'(bus.commit_valid_o), 32'd0);
        bus.alu1_complete_i = 1'b1; bus.alu1_rob_id_i = 5'd1;
        tick();
        bus.alu1_complete_i = 1'b0;
        check_val("c1_cvalid", 32'(bus.commit_valid_o), 32'd0);
        bus.alu0_complete_i = 1'b1; bus.alu0_rob_id_i = 5'd0;
        tick();
        bus.alu0_complete_i = 1'b0;
        check_val("c0_cvalid", 32'(bus.commit_valid_o), 32'd1);
        check_val("c0_cpack",  32'(bus.commit_pack_o),  32'd0);
        check_val("c0_cmask",  32'(bus.commit_mask_o),  32'd3);
        bus.commit_ready_i = 1'b1;
        tick();
        bus.commit_ready_i = 1'b0;
        check_val("pop_empty", 32'(bus.empty_o),        32'd1);
        check_val("pop_apack", 32'(bus.alloc_pack_o),   32'd1);

        // Fill to full, drop 17th, pop with simultaneous alloc
        flush();
        check_val("fl_empty", 32'(bus.empty_o),      32'd1);
        check_val("fl_apack", 32'(bus.alloc_pack_o), 32'd0);
        for (int i = 0; i < 16; i++) begin
            alloc(2'b11);
        end
        check_val("full16",    32'(bus.full_o),       32'd1);
        check_val("full16_ap", 32'(bus.alloc_pack_o), 32'd0);
        alloc(2'b11);
        check_val("full17",    32'(bus.full_o),       32'd1);
        check_val("full17_ap", 32'(bus.alloc_pack_o), 32'd0);
        bus.alu0_complete_i = 1'b1; bus.alu0_rob_id_i = 5'd0;
        bus.mem_complete_i  = 1'b1; bus.mem_rob_id_i  = 5'd1;
        tick();
        idle();
        check_val("fp_cvalid", 32'(bus.commit_valid_o), 32'd1);
        check_val("fp_cmask",  32'(bus.commit_mask_o),  32'd3);
        bus.commit_ready_i   = 1'b1;
        bus.alloc_valid_i    = 1'b1;
        bus.alloc_slot_vld_i = 2'b11;
        tick();
        idle();
        check_val("fp_full",   32'(bus.full_o),        32'd0);
        check_val("fp_apack",  32'(bus.alloc_pack_o),  32'd0);
        check_val("fp_cpack",  32'(bus.commit_pack_o), 32'd1);
        // two ports hitting the same slot, other slot still pending
        bus.alu1_complete_i = 1'b1; bus.alu1_rob_id_i = 5'd2;
        bus.mem_complete_i  = 1'b1; bus.mem_rob_id_i  = 5'd2;
        tick();
        idle();
        check_val("or_cvalid0", 32'(bus.commit_valid_o), 32'd0);
        bus.alu0_complete_i = 1'b1; bus.alu0_rob_id_i = 5'd3;
        tick();
        idle();
        check_val("or_cvalid1", 32'(bus.commit_valid_o), 32'd1);
        check_val("or_cpack",   32'(bus.commit_pack_o),  32'd1);
        check_val("or_cmask",   32'(bus.commit_mask_o),  32'd3);

        // Slot1 exception: partial commit then trap
        flush();
        alloc(2'b11);
        bus.excp_valid_i    = 1'b1; bus.excp_rob_i = 6'b100001; bus.excp_code_i = 5'd2;
        bus.alu0_complete_i = 1'b1; bus.alu0_rob_id_i = 5'd0;
        tick();
        idle();
        check_val("x1_cvalid", 32'(bus.commit_valid_o), 32'd1);
        check_val("x1_cmask",  32'(bus.commit_mask_o),  32'd1);
        check_val("x1_tvalid", 32'(bus.trap_valid_o),   32'd0);
        bus.commit_ready_i = 1'b1;
        tick();
        idle();
        check_val("x1_pop_cvalid", 32'(bus.commit_valid_o), 32'd0);
        check_val("x1_pop_empty",  32'(bus.empty_o),        32'd0);
        tick();
        check_val("x1_tvalid2", 32'(bus.trap_valid_o), 32'd1);
        check_val("x1_trob",    32'(bus.trap_rob_o),   32'd1);
        check_val("x1_tcode",   32'(bus.trap_code_o),  32'd2);
        alloc(2'b01);
        check_val("x1_trap_alloc", 32'(bus.alloc_pack_o),   32'd2);
        check_val("x1_trap_cv",    32'(bus.commit_valid_o), 32'd0);
        flush();
        check_reset_outputs("x1_flush");

        // Slot0 exception traps directly without commit
        alloc(2'b11);
        bus.excp_valid_i = 1'b1; bus.excp_rob_i = 6'd0; bus.excp_code_i = 5'd7;
        tick();
        idle();
        check_val("x0_cvalid", 32'(bus.commit_valid_o), 32'd0);
        tick();
        check_val("x0_tvalid", 32'(bus.trap_valid_o), 32'd1);
        check_val("x0_trob",   32'(bus.trap_rob_o),   32'd0);
        check_val("x0_tcode",  32'(bus.trap_code_o),  32'd7);
        flush();

        // Back-pressure holds commit outputs; flush beats same-cycle alloc
        alloc(2'b11);
        bus.alu0_complete_i = 1'b1; bus.alu0_rob_id_i = 5'd0;
        bus.alu1_complete_i = 1'b1; bus.alu1_rob_id_i = 5'd1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("hold_cvalid", 32'(bus.commit_valid_o), 32'd1);
            check_val("hold_cpack",  32'(bus.commit_pack_o),  32'd0);
            check_val("hold_cmask",  32'(bus.commit_mask_o),  32'd3);
        end
        bus.flush_i = 1'b1; bus.alloc_valid_i = 1'b1; bus.alloc_slot_vld_i = 2'b11;
        bus.commit_ready_i = 1'b1;
        tick();
        idle();
        check_val("fa_empty",  32'(bus.empty_o),        32'd1);
        check_val("fa_apack",  32'(bus.alloc_pack_o),   32'd0);
        check_val("fa_cvalid", 32'(bus.commit_valid_o), 32'd0);

        // Empty pack commits immediately with a zero mask
        alloc(2'b00);
        check_val("e_cvalid", 32'(bus.commit_valid_o), 32'd1);
        check_val("e_cmask",  32'(bus.commit_mask_o),  32'd0);
        flush();

        // Stray completions ignored; async reset mid-stream
        alloc(2'b01);
        bus.mem_complete_i  = 1'b1; bus.mem_rob_id_i  = 5'd20;
        bus.alu1_complete_i = 1'b1; bus.alu1_rob_id_i = 5'd1;
        tick();
        idle();
        check_val("st_cvalid", 32'(bus.commit_valid_o), 32'd0);
        check_val("st_apack",  32'(bus.alloc_pack_o),   32'd1);
        bus.alu0_complete_i = 1'b1; bus.alu0_rob_id_i = 5'd0;
        tick();
        idle();
        check_val("st_cvalid1", 32'(bus.commit_valid_o), 32'd1);
        check_val("st_cmask",   32'(bus.commit_mask_o),  32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        #3;
        rst_n = 1'b1;
        tick();
        check_reset_outputs("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
